// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared definitions for the data-memory controller.
//               Holds the access-size encodings, the controller state enum, and
//               the lane merge/extract helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  localparam logic [1:0] FMT_WORD = 2'b00;
  localparam logic [1:0] FMT_HALF = 2'b01;
  localparam logic [1:0] FMT_BYTE = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WR     = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Insert the low byte/halfword of new_data into old_word at the addressed
  // lane. A word access, or the unused 2'b11 size, replaces the whole word.
  // A halfword uses only off[1], so odd offsets are force-aligned.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_data,
                                             input logic [1:0]  fmt,
                                             input logic [1:0]  off);
    logic [31:0] merged;
    merged = old_word;
    case (fmt)
      FMT_HALF: merged[{off[1], 4'b0000} +: 16] = new_data[15:0];
      FMT_BYTE: merged[{off, 3'b000} +: 8]      = new_data[7:0];
      default:  merged                          = new_data;
    endcase
    return merged;
  endfunction

  // Pull the addressed lane out of a RAM word, right-aligned and zero-extended.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  fmt,
                                               input logic [1:0]  off);
    logic [31:0] result;
    case (fmt)
      FMT_HALF: result = {16'h0000, word[{off[1], 4'b0000} +: 16]};
      FMT_BYTE: result = {24'h000000, word[{off, 3'b000} +: 8]};
      default:  result = word;
    endcase
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_if
// Description : Core-to-data-memory bus. The core is the master and drives the
//               request fields; the controller is the slave and returns the
//               load data and completion status.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_if;
  logic [31:0] data_addr;
  logic [31:0] w_data;
  logic        dmem_r;
  logic        dmem_w;
  logic [1:0]  store_format_signal;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  modport master (
    output data_addr, w_data, dmem_r, dmem_w, store_format_signal,
    input  rdata, ready, busy, err
  );

  modport slave (
    input  data_addr, w_data, dmem_r, dmem_w, store_format_signal,
    output rdata, ready, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ram
// Description : Single-port synchronous word RAM. One-cycle read latency,
//               whole-word write enable, contents not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Write the addressed word when enabled; always read it for the next cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl
// Description : Data-memory controller for the multi-cycle core. Word stores,
//               read-modify-write partial stores and size-aware loads with
//               right-aligned, zero-extended results and a one-cycle ready.
//               Optional macro DMEM_ALIGN_CHECK_EN rejects misaligned word and
//               halfword accesses; without it those accesses are force-aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          AW          = 10
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  // Request decode, straight from the bus.
  logic [32:0]   offs_w;
  logic          oor_w;
  logic          misalign_w;
  logic          reject_w;
  logic [1:0]    fmt_w;
  logic          req_w;

  // Registered state.
  state_e        state_q,  state_d;
  logic [AW-1:0] idx_q,    idx_d;
  logic [1:0]    off_q,    off_d;
  logic [1:0]    fmt_q,    fmt_d;
  logic [31:0]   wdata_q,  wdata_d;
  logic [31:0]   rdata_q,  rdata_d;
  logic          ready_q,  ready_d;
  logic          busy_q,   busy_d;
  logic          err_q,    err_d;

  // RAM port.
  logic          ram_we_w;
  logic [AW-1:0] ram_addr_w;
  logic [31:0]   ram_rdata_w;

  // A 33-bit subtraction exposes underflow in bit 32; any set bit above the
  // word index means the address lies past the end of the RAM. BASE_ADDR is
  // word aligned, so the low two bits of the offset are the byte lane.
  assign offs_w = {1'b0, bus.data_addr} - {1'b0, BASE_ADDR};
  assign oor_w  = offs_w[32] | (|offs_w[31:AW+2]);
  assign fmt_w  = (bus.store_format_signal == 2'b11) ? FMT_WORD : bus.store_format_signal;
  assign req_w  = bus.dmem_r | bus.dmem_w;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign_w = ((fmt_w == FMT_WORD) && (offs_w[1:0] != 2'b00)) ||
                      ((fmt_w == FMT_HALF) && offs_w[0]);
`else
  assign misalign_w = 1'b0;
`endif

  assign reject_w = oor_w | misalign_w;

  // The read is launched on the accepting edge using the live address, so the
  // word is available in RD / RMW_RD. The write strobe comes from the state
  // flop, so an asynchronous reset drops it immediately.
  assign ram_addr_w = (state_q == ST_IDLE) ? offs_w[AW+1:2] : idx_q;
  assign ram_we_w   = (state_q == ST_WR);

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_w),
    .addr  (ram_addr_w),
    .wdata (wdata_q),
    .rdata (ram_rdata_w)
  );

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    off_d   = off_q;
    fmt_d   = fmt_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_w) begin
          idx_d   = offs_w[AW+1:2];
          off_d   = offs_w[1:0];
          fmt_d   = fmt_w;
          wdata_d = bus.w_data;
          if (reject_w) begin
            state_d = ST_DONE;
            ready_d = 1'b1;
            err_d   = 1'b1;
            // A rejected load returns zero; a rejected store leaves rdata.
            if (!bus.dmem_w) begin
              rdata_d = 32'h0;
            end
          end else if (bus.dmem_w) begin
            state_d = (fmt_w == FMT_WORD) ? ST_WR : ST_RMW_RD;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        rdata_d = lane_extract(ram_rdata_w, fmt_q, off_q);
        state_d = ST_DONE;
        ready_d = 1'b1;
      end
      ST_RMW_RD: begin
        wdata_d = lane_merge(ram_rdata_w, wdata_q, fmt_q, off_q);
        state_d = ST_WR;
      end
      ST_WR: begin
        state_d = ST_DONE;
        ready_d = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Register state and outputs; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      off_q   <= 2'b00;
      fmt_q   <= FMT_WORD;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      fmt_q   <= fmt_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_ctrl
// Description : Scoreboard bench for dmem_ctrl. A byte-addressed reference
//               model predicts each access; a monitor compares every ready
//               pulse against the queued prediction.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_ctrl;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 1024;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_if bus();

  dmem_ctrl #(
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (DEPTH),
    .AW          (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  logic [7:0]  bmem [logic [31:0]];
  logic [31:0] last_rdata = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ready pulse must match the oldest prediction.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && bus.ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got ready=1 expected no completion (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("err", {31'h0, bus.err}, {31'h0, e.err});
        check("rdata", bus.rdata, e.rdata);
        check("latency", cyc - e.t0, e.lat);
      end
    end
  end

  // Reference model for one access: addresses are plain byte addresses,
  // memory is a byte map, loads gather bytes little-endian.
  task automatic predict(input logic r, input logic w, input logic [1:0] fmt,
                         input logic [31:0] a, input logic [31:0] d, output exp_t e);
    int          n;
    logic [31:0] ea;
    longint      off;
    bit          bad;
    logic [31:0] v;
    n   = (fmt == 2'b01) ? 2 : ((fmt == 2'b10) ? 1 : 4);
    ea  = a & ~(32'(n) - 32'd1);
    off = longint'(a) - longint'(BASE);
    bad = (off < 0) || (off >= 4 * DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
    if (ea != a) bad = 1'b1;
`endif
    e.t0 = 0;
    if (bad) begin
      e.lat = 1;
      e.err = 1'b1;
      if (!w) last_rdata = 32'h0;
    end else if (w) begin
      for (int i = 0; i < n; i++) bmem[32'(ea + i)] = d[8*i +: 8];
      e.lat = (n == 4) ? 2 : 3;
      e.err = 1'b0;
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | ({24'h0, bmem[32'(ea + i)]} << (8 * i));
      last_rdata = v;
      e.lat = 2;
      e.err = 1'b0;
    end
    e.rdata = r ? last_rdata : last_rdata;
  endtask

  // Issue one access from an idle controller and wait for its completion.
  task automatic issue(input logic r, input logic w, input logic [1:0] fmt,
                       input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   k;
    predict(r, w, fmt, a, d, e);
    @(negedge clk);
    check("busy_idle", {31'h0, bus.busy}, 32'h0);
    bus.data_addr           = a;
    bus.w_data              = d;
    bus.store_format_signal = fmt;
    bus.dmem_r              = r;
    bus.dmem_w              = w;
    e.t0 = cyc;
    sb.push_back(e);
    @(negedge clk);
    bus.dmem_r    = 1'b0;
    bus.dmem_w    = 1'b0;
    bus.data_addr = $urandom;
    bus.w_data    = $urandom;
    check("busy_active", {31'h0, bus.busy}, 32'h1);
    k = 0;
    while (sb.size() != 0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no ready expected ready within 10 cycles (addr %h)", a);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    int          wi;
    logic [31:0] lastw;

    bus.data_addr           = 32'h0;
    bus.w_data              = 32'h0;
    bus.dmem_r              = 1'b0;
    bus.dmem_w              = 1'b0;
    bus.store_format_signal = 2'b00;

    repeat (3) @(negedge clk);
    check("rst_ready", {31'h0, bus.ready}, 32'h0);
    check("rst_busy",  {31'h0, bus.busy},  32'h0);
    check("rst_err",   {31'h0, bus.err},   32'h0);
    check("rst_rdata", bus.rdata,          32'h0);
    rst = 1'b0;

    // Give every word used below a known value.
    for (int i = 0; i < 8; i++) issue(1'b0, 1'b1, 2'b00, BASE + 32'(4 * i), $urandom);
    for (int i = DEPTH - 4; i < DEPTH; i++) issue(1'b0, 1'b1, 2'b00, BASE + 32'(4 * i), $urandom);

    // Word store/load, byte merge, halfword store and sub-word loads.
    issue(1'b0, 1'b1, 2'b00, 32'h1001_0004, 32'hDEAD_BEEF);
    issue(1'b1, 1'b0, 2'b00, 32'h1001_0004, 32'h0);
    issue(1'b0, 1'b1, 2'b10, 32'h1001_0005, 32'h0000_00AA);
    issue(1'b1, 1'b0, 2'b00, 32'h1001_0004, 32'h0);
    issue(1'b0, 1'b1, 2'b01, 32'h1001_0006, 32'h0000_1234);
    issue(1'b1, 1'b0, 2'b01, 32'h1001_0006, 32'h0);
    issue(1'b1, 1'b0, 2'b10, 32'h1001_0007, 32'h0);

    // Out-of-range on both sides; the boundary words stay intact.
    issue(1'b1, 1'b0, 2'b00, 32'h1000_FFFC, 32'h0);
    issue(1'b0, 1'b1, 2'b00, BASE + 32'(4 * DEPTH), 32'h5555_5555);
    issue(1'b1, 1'b0, 2'b00, BASE, 32'h0);
    issue(1'b1, 1'b0, 2'b00, BASE + 32'(4 * (DEPTH - 1)), 32'h0);

    // Reset during the read phase of a byte store must not commit the write.
    @(negedge clk);
    bus.data_addr           = 32'h1001_0014;
    bus.w_data              = 32'h0000_0077;
    bus.store_format_signal = 2'b10;
    bus.dmem_w              = 1'b1;
    @(negedge clk);
    bus.dmem_w = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_ready", {31'h0, bus.ready}, 32'h0);
    check("abort_busy",  {31'h0, bus.busy},  32'h0);
    check("abort_err",   {31'h0, bus.err},   32'h0);
    check("abort_rdata", bus.rdata,          32'h0);
    last_rdata = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(1'b1, 1'b0, 2'b00, 32'h1001_0014, 32'h0);

    // Misaligned word load: rejected or force-aligned depending on the build.
    issue(1'b1, 1'b0, 2'b00, 32'h1001_0002, 32'h0);
    issue(1'b1, 1'b0, 2'b01, 32'h1001_0003, 32'h0);
    issue(1'b1, 1'b0, 2'b11, 32'h1001_0008, 32'h0);

    // Randomized mix of sizes, directions and addresses.
    for (int t = 0; t < 120; t++) begin
      case ($urandom_range(0, 7))
        0: a = BASE - 32'($urandom_range(1, 16));
        1: a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 64));
        2: a = 32'hFFFF_FFFC;
        default: begin
          wi = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : (DEPTH - 4 + $urandom_range(0, 3));
          a  = BASE + 32'(4 * wi) + 32'($urandom_range(0, 3));
        end
      endcase
      lastw = $urandom;
      case ($urandom_range(0, 4))
        0, 1:    issue(1'b1, 1'b0, 2'($urandom_range(0, 3)), a, lastw);
        2, 3:    issue(1'b0, 1'b1, 2'($urandom_range(0, 3)), a, lastw);
        default: issue(1'b1, 1'b1, 2'($urandom_range(0, 3)), a, lastw);
      endcase
    end

    // Read back every tracked word so all stores are observed.
    for (int i = 0; i < 8; i++) issue(1'b1, 1'b0, 2'b00, BASE + 32'(4 * i), 32'h0);
    for (int i = DEPTH - 4; i < DEPTH; i++) issue(1'b1, 1'b0, 2'b00, BASE + 32'(4 * i), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the stimulus itself stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1);
  end

endmodule
`default_nettype wire
